mmff_bank: RTL and testbench

Parametrised multi-mode register bank: successor to the single-bit multi-mode flip-flop primitive used inside the CLB fabric mode. One configuration word (loaded through a local configuration shift chain) selects the bank's operating mode. Modes are plain DFF, DFF with clock-enable, serial shift register, or up-counter. The bank also provides a configurable clear polarity and clear value. Sits in the logical tile as a p_ff-class primitive, chained into the tile's configuration path.

---
 rtl/mmff_bank_pkg.sv | 24 ++
 rtl/mmff_bank_cfg_chain.sv | 27 ++
 rtl/mmff_bank.sv | 78 +++++++
 tb/tb_mmff_bank.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mmff_bank_pkg.sv
// Shared definitions for the multi-mode register bank: operating modes,
// configuration word layout and the configuration reset word.
package mmff_bank_pkg;

    localparam int CFG_BITS   = 4;
    localparam int CFG_OP_LSB = 0;
    localparam int CFG_CLRPOL = 2;
    localparam int CFG_CLRVAL = 3;

    // Reset word: plain DFF, clear active-high, clear value zero
    localparam logic [CFG_BITS-1:0] CFG_RST = 4'b0100;

    typedef enum logic [1:0] {
        OP_DFF    = 2'd0,
        OP_DFF_CE = 2'd1,
        OP_SHIFT  = 2'd2,
        OP_COUNT  = 2'd3
    } op_e;

    function automatic logic clr_is_active(input logic clr, input logic pol);
        return pol ? clr : ~clr;
    endfunction

endpackage

// File: rtl/mmff_bank_cfg_chain.sv
// Serial-in parallel-out configuration register for one bank; its MSB
// continues the tile configuration chain.
module mmff_bank_cfg_chain
    import mmff_bank_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                en_i,
    input  logic                d_i,
    output logic [CFG_BITS-1:0] q_o,
    output logic                so_o
);

    logic [CFG_BITS-1:0] cfg_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cfg_q <= CFG_RST;
        end else if (en_i) begin
            cfg_q <= {cfg_q[CFG_BITS-2:0], d_i};
        end
    end

    assign q_o  = cfg_q;
    assign so_o = cfg_q[CFG_BITS-1];

endmodule

// File: rtl/mmff_bank.sv
// Multi-mode register bank: DFF, DFF with enable, shift register or
// up-counter, selected by a word loaded through the local config chain.
module mmff_bank #(
    parameter int WIDTH    = 4,
    parameter int CFG_BITS = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cfg_en_i,
    input  logic             cfg_d_i,
    output logic             cfg_q_o,
    input  logic [WIDTH-1:0] d_i,
    input  logic             ce_i,
    input  logic             clr_i,
    input  logic             set_i,
    input  logic             sin_i,
    output logic [WIDTH-1:0] q_o,
    output logic             sout_o,
    output logic             tc_o
);

    import mmff_bank_pkg::*;

    logic [CFG_BITS-1:0] cfg_word;
    logic [WIDTH-1:0]    q_q;
    logic [WIDTH-1:0]    q_d;
    logic [WIDTH-1:0]    clr_value;
    logic [WIDTH-1:0]    one;
    op_e                 op;
    logic                clr_act;

    mmff_bank_cfg_chain u_cfg_chain (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .en_i  (cfg_en_i),
        .d_i   (cfg_d_i),
        .q_o   (cfg_word),
        .so_o  (cfg_q_o)
    );

    assign op        = op_e'(cfg_word[CFG_OP_LSB +: 2]);
    assign clr_act   = clr_is_active(clr_i, cfg_word[CFG_CLRPOL]);
    assign clr_value = {WIDTH{cfg_word[CFG_CLRVAL]}};
    assign one       = {{(WIDTH-1){1'b0}}, 1'b1};

    // Configuration shifting freezes the datapath; otherwise clear beats set beats mode action
    always_comb begin
        q_d = q_q;
        if (!cfg_en_i) begin
            if (clr_act) begin
                q_d = clr_value;
            end else if (set_i) begin
                q_d = '1;
            end else begin
                case (op)
                    OP_DFF:    q_d = d_i;
                    OP_DFF_CE: q_d = ce_i ? d_i : q_q;
                    OP_SHIFT:  q_d = ce_i ? {q_q[WIDTH-2:0], sin_i} : q_q;
                    OP_COUNT:  q_d = ce_i ? q_q + one : q_q;
                    default:   q_d = q_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o    = q_q;
    assign sout_o = q_q[WIDTH-1];
    assign tc_o   = (op == OP_COUNT) & ce_i & (&q_q) & ~clr_act & ~set_i & ~cfg_en_i;

endmodule

// File: tb/tb_mmff_bank.sv
// Directed self-checking bench for mmff_bank: expected register contents are
// queued when each step is driven and compared after the clock edge.
module tb_mmff_bank;

    localparam int W = 4;

    logic         clk_i;
    logic         rst_ni;
    logic         cfg_en_i;
    logic         cfg_d_i;
    logic         cfg_q_o;
    logic [W-1:0] d_i;
    logic         ce_i;
    logic         clr_i;
    logic         set_i;
    logic         sin_i;
    logic [W-1:0] q_o;
    logic         sout_o;
    logic         tc_o;

    typedef struct {
        logic [W-1:0] q;
        logic         cfgQ;
        string        tag;
    } expT;

    expT  sb[$];
    int   checks   = 0;
    int   failures = 0;
    logic lastCfgQ = 1'b0;

    mmff_bank #(.WIDTH(W), .CFG_BITS(4)) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .cfg_en_i(cfg_en_i),
        .cfg_d_i (cfg_d_i),
        .cfg_q_o (cfg_q_o),
        .d_i     (d_i),
        .ce_i    (ce_i),
        .clr_i   (clr_i),
        .set_i   (set_i),
        .sin_i   (sin_i),
        .q_o     (q_o),
        .sout_o  (sout_o),
        .tc_o    (tc_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        expT e;
        checkValue("scoreboard_nonempty", {31'd0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            checkValue({e.tag, ".q"}, {28'd0, q_o}, {28'd0, e.q});
            checkValue({e.tag, ".sout"}, {31'd0, sout_o}, {31'd0, e.q[W-1]});
            checkValue({e.tag, ".cfgq"}, {31'd0, cfg_q_o}, {31'd0, e.cfgQ});
        end
    endtask

    // Drive one cycle of inputs, check tc_o before the edge, queue the post-edge expectation
    task automatic applyStimulus(input string tag, input logic cfgEn, input logic cfgD,
                                 input logic [W-1:0] d, input logic ce, input logic clr,
                                 input logic set, input logic sin, input logic expTc,
                                 input logic [W-1:0] expQ, input logic expCfgQ);
        expT e;
        @(negedge clk_i);
        cfg_en_i = cfgEn;
        cfg_d_i  = cfgD;
        d_i      = d;
        ce_i     = ce;
        clr_i    = clr;
        set_i    = set;
        sin_i    = sin;
        #1;
        checkValue({tag, ".tc"}, {31'd0, tc_o}, {31'd0, expTc});
        e.q    = expQ;
        e.cfgQ = expCfgQ;
        e.tag  = tag;
        sb.push_back(e);
        @(posedge clk_i);
        #1;
        checkOutput();
    endtask

    // Config shift with every datapath input asserted to show they are ignored
    task automatic cfgShift(input string tag, input logic bitIn, input logic [W-1:0] expQ,
                            input logic expCfgQ);
        lastCfgQ = expCfgQ;
        applyStimulus(tag, 1'b1, bitIn, ~expQ, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, expQ, expCfgQ);
    endtask

    task automatic run(input string tag, input logic [W-1:0] d, input logic ce, input logic clr,
                       input logic set, input logic sin, input logic expTc, input logic [W-1:0] expQ);
        applyStimulus(tag, 1'b0, 1'b0, d, ce, clr, set, sin, expTc, expQ, lastCfgQ);
    endtask

    initial begin
        rst_ni   = 1'b0;
        cfg_en_i = 1'b0;
        cfg_d_i  = 1'b0;
        d_i      = '0;
        ce_i     = 1'b0;
        clr_i    = 1'b0;
        set_i    = 1'b0;
        sin_i    = 1'b0;
        #12;
        checkValue("rst.q", {28'd0, q_o}, 32'd0);
        checkValue("rst.cfgq", {31'd0, cfg_q_o}, 32'd0);
        checkValue("rst.sout", {31'd0, sout_o}, 32'd0);
        checkValue("rst.tc", {31'd0, tc_o}, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Reset configuration is plain DFF with active-high clear to zero
        run("dff_a",   4'hA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'hA);
        run("dff_set", 4'h3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'hF);
        run("dff_a2",  4'hA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'hA);

        // Load 4'b0101: DFF_CE; old word 0100 leaves MSB-first
        cfgShift("cfg_ce0", 1'b0, 4'hA, 1'b1);
        cfgShift("cfg_ce1", 1'b1, 4'hA, 1'b0);
        cfgShift("cfg_ce2", 1'b0, 4'hA, 1'b0);
        cfgShift("cfg_ce3", 1'b1, 4'hA, 1'b0);
        run("ce_hold", 4'h5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'hA);
        run("ce_load", 4'h5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h5);

        cfgShift("cfg_re0", 1'b0, 4'h5, 1'b1);
        cfgShift("cfg_re1", 1'b1, 4'h5, 1'b0);
        cfgShift("cfg_re2", 1'b0, 4'h5, 1'b1);
        cfgShift("cfg_re3", 1'b1, 4'h5, 1'b0);

        // Load 4'b0110: SHIFT
        cfgShift("cfg_sh0", 1'b0, 4'h5, 1'b1);
        cfgShift("cfg_sh1", 1'b1, 4'h5, 1'b0);
        cfgShift("cfg_sh2", 1'b1, 4'h5, 1'b1);
        cfgShift("cfg_sh3", 1'b0, 4'h5, 1'b0);
        run("sh_clrset", 4'hF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
        run("sh_1",      4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h1);
        run("sh_2",      4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h2);
        run("sh_3",      4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h5);
        run("sh_4",      4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'hB);
        run("sh_hold",   4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'hB);
        run("sh_5",      4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h7);
        run("sh_6",      4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'hF);
        run("sh_7",      4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'hE);

        // Load 4'b0111: COUNT
        cfgShift("cfg_ct0", 1'b0, 4'hE, 1'b1);
        cfgShift("cfg_ct1", 1'b1, 4'hE, 1'b1);
        cfgShift("cfg_ct2", 1'b1, 4'hE, 1'b0);
        cfgShift("cfg_ct3", 1'b1, 4'hE, 1'b0);
        run("cnt_e",    4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF);
        run("cnt_hold", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF);
        run("cnt_set",  4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'hF);
        run("cnt_clr",  4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
        run("cnt_set2", 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'hF);
        run("cnt_wrap", 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0);
        run("cnt_one",  4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1);

        // Load 4'b1011: COUNT, clear active-low, clear value ones
        cfgShift("cfg_pl0", 1'b1, 4'h1, 1'b1);
        cfgShift("cfg_pl1", 1'b0, 4'h1, 1'b1);
        cfgShift("cfg_pl2", 1'b1, 4'h1, 1'b1);
        cfgShift("cfg_pl3", 1'b1, 4'h1, 1'b1);
        run("pol_clrset", 4'h3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'hF);
        run("pol_cnt",    4'h3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'h0);
        run("pol_clr",    4'h3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF);

        // Partial config (1011 -> 0111 -> 1110) discarded by async reset between edges
        cfgShift("cfg_pa0", 1'b1, 4'hF, 1'b0);
        cfgShift("cfg_pa1", 1'b0, 4'hF, 1'b1);
        #1;
        rst_ni   = 1'b0;
        cfg_en_i = 1'b0;
        clr_i    = 1'b0;
        set_i    = 1'b0;
        #1;
        checkValue("arst.q", {28'd0, q_o}, 32'd0);
        checkValue("arst.cfgq", {31'd0, cfg_q_o}, 32'd0);
        checkValue("arst.sout", {31'd0, sout_o}, 32'd0);
        rst_ni   = 1'b1;
        lastCfgQ = 1'b0;
        run("arst_dff",  4'h9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h9);
        run("arst_clr",  4'h6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
        run("arst_dff2", 4'h6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
